// File: rtl/draw_rectangle_stream.sv
// Rectangle point generator: streams outline or filled rectangle coordinates
// over a valid/ready interface; _start resets the block and latches a command.
`timescale 1ns/1ps
module draw_rectangle_stream #(
  parameter int WIDTH = 32
) (
  input  logic                    _clock,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] s_x,
  input  logic signed [WIDTH-1:0] s_y,
  input  logic signed [WIDTH-1:0] height,
  input  logic signed [WIDTH-1:0] width,
  input  logic                    fill,
  input  logic                    _ready,
  output logic signed [WIDTH-1:0] _out0,
  output logic signed [WIDTH-1:0] _out1,
  output logic                    _valid,
  output logic                    _done
);

  localparam logic signed [WIDTH-1:0] ZERO = WIDTH'(0);
  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [2:0] {
    LOAD, OUTLINE_COLS, OUTLINE_ROWS, FILL, DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] org_x, org_y, size_h, size_w;
  logic                    fill_mode;
  logic signed [WIDTH-1:0] outer, outer_nxt, inner, inner_nxt;
  logic                    side, side_nxt;
  logic signed [WIDTH-1:0] out0_nxt, out1_nxt;
  logic                    valid_nxt, done_nxt;
  logic                    xfer;
  logic signed [WIDTH-1:0] outer_inc, inner_inc;

  assign xfer      = _valid & _ready;
  assign outer_inc = outer + ONE;
  assign inner_inc = inner + ONE;

  // Command latch on _start, otherwise advance the sequence.
  always_ff @(posedge _clock) begin
    if (_start) begin
      org_x     <= s_x;
      org_y     <= s_y;
      size_h    <= height;
      size_w    <= width;
      fill_mode <= fill;
      state     <= LOAD;
      outer     <= ZERO;
      inner     <= ZERO;
      side      <= 1'b0;
      _out0     <= ZERO;
      _out1     <= ZERO;
      _valid    <= 1'b0;
      _done     <= 1'b0;
    end else begin
      state  <= state_nxt;
      outer  <= outer_nxt;
      inner  <= inner_nxt;
      side   <= side_nxt;
      _out0  <= out0_nxt;
      _out1  <= out1_nxt;
      _valid <= valid_nxt;
      _done  <= done_nxt;
    end
  end

  // Next point is computed only on a transfer, so outputs hold under stall.
  always_comb begin
    state_nxt = state;
    outer_nxt = outer;
    inner_nxt = inner;
    side_nxt  = side;
    out0_nxt  = _out0;
    out1_nxt  = _out1;
    valid_nxt = _valid;
    done_nxt  = _done;
    unique case (state)
      LOAD: begin
        if (size_h < ONE || size_w < ONE) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = fill_mode ? FILL : OUTLINE_COLS;
          outer_nxt = ZERO;
          inner_nxt = ZERO;
          side_nxt  = 1'b0;
          out0_nxt  = org_x;
          out1_nxt  = org_y;
          valid_nxt = 1'b1;
        end
      end
      OUTLINE_COLS: begin
        if (xfer) begin
          if (!side) begin
            side_nxt = 1'b1;
            out0_nxt = org_x + size_h - ONE;
            out1_nxt = org_y + outer;
          end else if (outer_inc < size_w) begin
            side_nxt  = 1'b0;
            outer_nxt = outer_inc;
            out0_nxt  = org_x;
            out1_nxt  = org_y + outer_inc;
          end else begin
            state_nxt = OUTLINE_ROWS;
            side_nxt  = 1'b0;
            outer_nxt = ZERO;
            out0_nxt  = org_x;
            out1_nxt  = org_y;
          end
        end
      end
      OUTLINE_ROWS: begin
        if (xfer) begin
          if (!side) begin
            side_nxt = 1'b1;
            out0_nxt = org_x + outer;
            out1_nxt = org_y + size_w - ONE;
          end else if (outer_inc < size_h) begin
            side_nxt  = 1'b0;
            outer_nxt = outer_inc;
            out0_nxt  = org_x + outer_inc;
            out1_nxt  = org_y;
          end else begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      FILL: begin
        if (xfer) begin
          if (inner_inc < size_w) begin
            inner_nxt = inner_inc;
            out1_nxt  = org_y + inner_inc;
          end else if (outer_inc < size_h) begin
            outer_nxt = outer_inc;
            inner_nxt = ZERO;
            out0_nxt  = org_x + outer_inc;
            out1_nxt  = org_y;
          end else begin
            state_nxt = DONE;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      DONE: ;
      default: state_nxt = DONE;
    endcase
  end

endmodule

// File: tb/tb_draw_rectangle_stream.sv
// Directed bench for draw_rectangle_stream: outline, fill, back-pressure,
// degenerate sizes, restart and 8-bit wrap-around.
`timescale 1ns/1ps
module tb_draw_rectangle_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               start, ready, fill, valid, done;
  logic signed [31:0] s_x, s_y, height, width, out0, out1;

  logic              start8, ready8, valid8, done8;
  logic signed [7:0] out0_8, out1_8;

  int errors = 0;
  int checks = 0;
  int e0[32];
  int e1[32];
  int n_exp;

  draw_rectangle_stream #(.WIDTH(32)) dut (
    ._clock(clk), ._start(start), .s_x(s_x), .s_y(s_y), .height(height),
    .width(width), .fill(fill), ._ready(ready), ._out0(out0), ._out1(out1),
    ._valid(valid), ._done(done)
  );

  draw_rectangle_stream #(.WIDTH(8)) dut8 (
    ._clock(clk), ._start(start8), .s_x(8'sd127), .s_y(8'sd0), .height(8'sd2),
    .width(8'sd1), .fill(1'b1), ._ready(ready8), ._out0(out0_8), ._out1(out1_8),
    ._valid(valid8), ._done(done8)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b);
    e0[n_exp] = a;
    e1[n_exp] = b;
    n_exp++;
  endtask

  // One cycle with _start high, check the cleared outputs, then release.
  task automatic load_cmd(input int sx, input int sy, input int h, input int w,
                          input logic f);
    start = 1'b1; s_x = sx; s_y = sy; height = h; width = w; fill = f;
    ready = 1'b0;
    tick();
    check("start_valid", 32'(valid), 0);
    check("start_done", 32'(done), 0);
    check("start_out0", out0, 0);
    check("start_out1", out1, 0);
    start = 1'b0;
    n_exp = 0;
    // Inputs changing after _start falls must not matter.
    s_x = 999; s_y = 999; height = 0; width = 0; fill = ~f;
  endtask

  // Consume n_exp points; bp selects a 1,0,0 ready pattern.
  task automatic run_stream(input bit bp, input bit full);
    int k = 0;
    int cyc = 0;
    logic hold;
    logic signed [31:0] h0, h1;
    while (k < n_exp && cyc < 200) begin
      ready = bp ? (cyc % 3 == 0) : 1'b1;
      hold = valid && !ready;
      h0 = out0; h1 = out1;
      if (valid && ready) begin
        check($sformatf("pt%0d_row", k), out0, e0[k]);
        check($sformatf("pt%0d_col", k), out1, e1[k]);
        check($sformatf("pt%0d_done", k), 32'(done), 0);
        k++;
      end
      tick();
      cyc++;
      if (hold) begin
        check("stall_valid", 32'(valid), 1);
        check("stall_row", out0, h0);
        check("stall_col", out1, h1);
      end
    end
    check("point_count", k, n_exp);
    if (full) begin
      if (!bp) check("cycles", cyc, n_exp + 1);
      check("end_valid", 32'(valid), 0);
      check("end_done", 32'(done), 1);
      ready = 1'b1;
      tick();
      check("after_valid", 32'(valid), 0);
      check("after_done", 32'(done), 1);
      check("after_row", out0, e0[n_exp-1]);
      check("after_col", out1, e1[n_exp-1]);
    end
  endtask

  task automatic outline_exp();
    n_exp = 0;
    push(10, 20); push(12, 20); push(10, 21); push(12, 21); push(10, 20);
    push(10, 21); push(11, 20); push(11, 21); push(12, 20); push(12, 21);
  endtask

  task automatic fill_exp();
    n_exp = 0;
    push(0, 0); push(0, 1); push(0, 2); push(1, 0); push(1, 1); push(1, 2);
  endtask

  initial begin
    start = 1'b1; ready = 1'b0; fill = 1'b0;
    s_x = 0; s_y = 0; height = 0; width = 0;
    start8 = 1'b1; ready8 = 1'b0;

    // Outline, continuous ready.
    load_cmd(10, 20, 3, 2, 1'b0);
    outline_exp();
    run_stream(1'b0, 1'b1);

    // Filled, continuous ready.
    load_cmd(0, 0, 2, 3, 1'b1);
    fill_exp();
    run_stream(1'b0, 1'b1);

    // Filled with back-pressure.
    load_cmd(0, 0, 2, 3, 1'b1);
    fill_exp();
    run_stream(1'b1, 1'b1);

    // Degenerate sizes.
    load_cmd(3, 4, 5, 0, 1'b0);
    tick();
    check("deg_w0_valid", 32'(valid), 0);
    check("deg_w0_done", 32'(done), 1);
    load_cmd(3, 4, -1, 4, 1'b1);
    tick();
    check("deg_hneg_valid", 32'(valid), 0);
    check("deg_hneg_done", 32'(done), 1);
    tick();
    check("deg_hneg_hold", 32'(valid), 0);

    // Restart after the 3rd outline transfer.
    load_cmd(10, 20, 3, 2, 1'b0);
    outline_exp();
    n_exp = 3;
    run_stream(1'b0, 1'b0);
    check("pre_restart_valid", 32'(valid), 1);
    load_cmd(-1, -1, 1, 1, 1'b1);
    start = 1'b1; s_x = -1; s_y = -1; height = 1; width = 1; fill = 1'b1;
    ready = 1'b1;
    tick();
    check("restart_hold_valid", 32'(valid), 0);
    check("restart_hold_done", 32'(done), 0);
    start = 1'b0;
    n_exp = 0;
    push(-1, -1);
    run_stream(1'b0, 1'b1);

    // 8-bit wrap: rows 127 then -128.
    start8 = 1'b1;
    tick();
    check("w8_start_valid", 32'(valid8), 0);
    start8 = 1'b0;
    ready8 = 1'b1;
    tick();
    check("w8_p0_valid", 32'(valid8), 1);
    check("w8_p0_row", 32'(out0_8), 127);
    check("w8_p0_col", 32'(out1_8), 0);
    tick();
    check("w8_p1_valid", 32'(valid8), 1);
    check("w8_p1_row", 32'(out0_8), -128);
    check("w8_p1_col", 32'(out1_8), 0);
    tick();
    check("w8_end_valid", 32'(valid8), 0);
    check("w8_end_done", 32'(done8), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
